// File: rtl/reg_arbiter.sv
// Four-requester round-robin arbiter that loads a shared register from the winning requester
// and holds it for HOLD_CYC cycles before it samples the requests again.
module reg_arbiter #(
    parameter int DW       = 8,
    parameter int HOLD_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      gnt,
    output logic [DW-1:0]   q,
    output logic [DW-1:0]   qb,
    output logic [1:0]      owner,
    output logic            busy
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_HOLD   = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYC - 1);

    logic [0:0]    r_state;
    logic [3:0]    r_cnt;
    logic [1:0]    r_last;
    logic [3:0]    r_gnt;
    logic [DW-1:0] r_q;
    logic [1:0]    r_owner;
    logic          r_busy;

    logic          w_found;
    logic [1:0]    w_sel;
    logic [1:0]    w_idx;
    logic [DW-1:0] w_din_sel;

    // Search upward from the requester after the last winner, wrapping modulo 4.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_din_sel = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (2'(i) == w_sel) begin
                w_din_sel = din[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_gnt   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= 4'b0001 << w_sel;
                        r_q     <= w_din_sel;
                        r_owner <= w_sel;
                        r_last  <= w_sel;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign q     = r_q;
    assign qb    = ~r_q;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_reg_arbiter.sv
// Table-driven scoreboard bench for reg_arbiter (DW=8, HOLD_CYC=3) plus a hand-written
// asynchronous-reset-during-hold sequence.
module tb_reg_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  qb;
    logic [1:0]  owner;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    reg_arbiter #(.DW(8), .HOLD_CYC(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .q     (q),
        .qb    (qb),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                       input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o,
                       input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.din = d; v.gnt = g; v.q = qq; v.owner = o; v.busy = b;
        tbl.push_back(v);
    endtask

    // Three cycles following a grant: busy stays high for two more, then drops.
    task automatic hold3(input logic [3:0] rq, input logic [31:0] d, input logic [7:0] qq,
                         input logic [1:0] o);
        add(1'b1, rq, d, 4'b0000, qq, o, 1'b1);
        add(1'b1, rq, d, 4'b0000, qq, o, 1'b1);
        add(1'b1, rq, d, 4'b0000, qq, o, 1'b0);
    endtask

    // Invariants checked every cycle, away from the stimulus edge.
    always @(posedge clk) begin
        #3;
        chk("qb_is_not_q", {24'h0, qb}, {24'h0, ~q});
        chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        vec_t e;
        rst = 1'b0;
        req = 4'h0;
        din = '0;

        // Reset held with all requests active.
        add(1'b0, 4'hF, 32'hFFFF_FFFF, 4'b0000, 8'h00, 2'd0, 1'b0);
        add(1'b0, 4'hF, 32'hFFFF_FFFF, 4'b0000, 8'h00, 2'd0, 1'b0);
        // Single request from requester 2.
        add(1'b1, 4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 2'd2, 1'b1);
        hold3(4'b0000, 32'h00A5_0000, 8'hA5, 2'd2);
        // Hold ignore: din[owner] changes and all requests rise during hold.
        add(1'b1, 4'b0001, 32'h0000_003C, 4'b0001, 8'h3C, 2'd0, 1'b1);
        hold3(4'hF, 32'hEEEE_EEEE, 8'h3C, 2'd0);
        add(1'b1, 4'hF, 32'h4433_2211, 4'b0010, 8'h22, 2'd1, 1'b1);
        hold3(4'b0000, 32'h4433_2211, 8'h22, 2'd1);
        // Serve 3, then wrap to 0 with req=1001.
        add(1'b1, 4'b1000, 32'h7700_0000, 4'b1000, 8'h77, 2'd3, 1'b1);
        hold3(4'b0000, 32'h7700_0000, 8'h77, 2'd3);
        add(1'b1, 4'b1001, 32'h7700_0055, 4'b0001, 8'h55, 2'd0, 1'b1);
        hold3(4'b0000, 32'h7700_0055, 8'h55, 2'd0);
        // Round robin from a fresh reset with all requests held.
        add(1'b0, 4'hF, 32'h1312_1110, 4'b0000, 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            add(1'b1, 4'hF, 32'h1312_1110, 4'(1 << i), 8'(8'h10 + i), 2'(i), 1'b1);
            hold3(4'hF, 32'h1312_1110, 8'(8'h10 + i), 2'(i));
        end
        add(1'b1, 4'hF, 32'h1312_1110, 4'b0001, 8'h10, 2'd0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            req = tbl[i].req;
            din = tbl[i].din;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_gnt", i),   {28'h0, gnt},   {28'h0, e.gnt});
            chk($sformatf("v%0d_q", i),     {24'h0, q},     {24'h0, e.q});
            chk($sformatf("v%0d_qb", i),    {24'h0, qb},    {24'h0, ~e.q});
            chk($sformatf("v%0d_owner", i), {30'h0, owner}, {30'h0, e.owner});
            chk($sformatf("v%0d_busy", i),  {31'h0, busy},  {31'h0, e.busy});
        end

        // Reset asserted mid-hold takes effect without a clock edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_busy",  {31'h0, busy},  32'd0);
        chk("arst_q",     {24'h0, q},     32'h00);
        chk("arst_qb",    {24'h0, qb},    32'hFF);
        chk("arst_gnt",   {28'h0, gnt},   32'h0);
        chk("arst_owner", {30'h0, owner}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_held_gnt",  {28'h0, gnt},  32'h0);
        chk("arst_held_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1000;
        din = 32'h9A00_0000;
        @(posedge clk);
        #1;
        chk("post_rst_gnt",   {28'h0, gnt},   32'h8);
        chk("post_rst_q",     {24'h0, q},     32'h9A);
        chk("post_rst_owner", {30'h0, owner}, 32'd3);
        chk("post_rst_busy",  {31'h0, busy},  32'd1);
        @(negedge clk);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_hold%0d_gnt", c), {28'h0, gnt}, 32'h0);
        end
        chk("post_rst_busy_end", {31'h0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("no_resume_gnt", {28'h0, gnt}, 32'h0);
        chk("no_resume_q",   {24'h0, q},   32'h9A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
